// File: rtl/icap_stream_writer.sv
// ICAP write initiator: streams a 32-bit AXI-Stream bitstream into an ICAPE3 port.
// Handles AVAIL stalls, optional per-byte bit reversal, PR done/error and timeout.
module icap_stream_writer #(
    parameter int BIT_SWAP       = 1,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [31:0]      s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    input  logic             ICAP_AVAIL,
    input  logic [31:0]      ICAP_O,
    input  logic             ICAP_PRDONE,
    input  logic             ICAP_PRERROR,
    output logic             ICAP_CSIB,
    output logic [31:0]      ICAP_I,
    output logic             ICAP_RDWRB,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WRITE,
        S_WAIT,
        S_DRAIN,
        S_FIN
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_PR   = 2'b01;
    localparam logic [1:0] ERR_TO   = 2'b10;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic             r_csib;
    logic             r_rdwrb;
    logic [31:0]      r_i;
    logic             r_done;
    logic             r_error;
    logic [1:0]       r_err_code;
    logic [CNT_W-1:0] r_word_count;
    logic [CNT_W-1:0] r_to_cnt;

    state_t           w_next;
    logic             w_csib;
    logic             w_rdwrb;
    logic [31:0]      w_i;
    logic             w_done;
    logic             w_error;
    logic [1:0]       w_err_code;
    logic [CNT_W-1:0] w_word_count;
    logic [CNT_W-1:0] w_to_cnt;
    logic             w_tready;
    logic             w_beat;
    logic [31:0]      w_data;
    logic             w_unused_icap_o;

    // Readback path is never used by a write-only initiator
    assign w_unused_icap_o = ^ICAP_O;

    function automatic logic [31:0] f_swap(input logic [31:0] d);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 8; j++) begin
                r[8*k+j] = d[8*k+7-j];
            end
        end
        return r;
    endfunction

    assign w_data = (BIT_SWAP != 0) ? f_swap(s_axis_tdata) : s_axis_tdata;

    always_comb begin
        w_tready = 1'b0;
        unique case (r_state)
            S_WRITE: w_tready = ICAP_AVAIL;
            S_DRAIN: w_tready = 1'b1;
            default: w_tready = 1'b0;
        endcase
    end

    assign w_beat = s_axis_tvalid & w_tready;

    always_comb begin
        w_next       = r_state;
        w_csib       = 1'b1;
        w_rdwrb      = r_rdwrb;
        w_i          = r_i;
        w_done       = 1'b0;
        w_error      = r_error;
        w_err_code   = r_err_code;
        w_word_count = r_word_count;
        w_to_cnt     = r_to_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next       = S_ARM;
                    w_error      = 1'b0;
                    w_err_code   = ERR_NONE;
                    w_word_count = '0;
                end
            end
            S_ARM: begin
                w_rdwrb = 1'b0;
                w_next  = S_WRITE;
            end
            S_WRITE: begin
                if (ICAP_PRERROR) begin
                    // Error wins over a same-cycle beat; that beat is dropped
                    w_err_code = ERR_PR;
                    w_next     = (w_beat && s_axis_tlast) ? S_FIN : S_DRAIN;
                end else if (w_beat) begin
                    w_csib       = 1'b0;
                    w_i          = w_data;
                    w_word_count = r_word_count + CNT_W'(1);
                    if (s_axis_tlast) begin
                        w_next   = S_WAIT;
                        w_to_cnt = '0;
                    end
                end
            end
            S_WAIT: begin
                w_to_cnt = r_to_cnt + CNT_W'(1);
                if (ICAP_PRERROR) begin
                    w_err_code = ERR_PR;
                    w_next     = S_FIN;
                end else if (ICAP_PRDONE) begin
                    w_next = S_FIN;
                end else if (r_to_cnt == TO_LAST) begin
                    w_err_code = ERR_TO;
                    w_next     = S_FIN;
                end
            end
            S_DRAIN: begin
                if (w_beat && s_axis_tlast) begin
                    w_next = S_FIN;
                end
            end
            S_FIN: begin
                w_rdwrb = 1'b1;
                w_next  = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // done/error are registered, so they are loaded on the edge into FIN
        if (w_next == S_FIN && r_state != S_FIN) begin
            w_done  = 1'b1;
            w_error = (w_err_code != ERR_NONE);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_csib       <= 1'b1;
            r_rdwrb      <= 1'b1;
            r_i          <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_word_count <= '0;
            r_to_cnt     <= '0;
        end else begin
            r_state      <= w_next;
            r_csib       <= w_csib;
            r_rdwrb      <= w_rdwrb;
            r_i          <= w_i;
            r_done       <= w_done;
            r_error      <= w_error;
            r_err_code   <= w_err_code;
            r_word_count <= w_word_count;
            r_to_cnt     <= w_to_cnt;
        end
    end

    assign s_axis_tready = w_tready;
    assign ICAP_CSIB     = r_csib;
    assign ICAP_I        = r_i;
    assign ICAP_RDWRB    = r_rdwrb;
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign error         = r_error;
    assign err_code      = r_err_code;
    assign word_count    = r_word_count;

endmodule
